// File: rtl/voice_allocator.sv
// Polyphonic voice allocator driving the gates of a bank of adsr envelopes.
// Note-on selection order: held voice already playing the note (retrigger),
// lowest-index free voice, oldest releasing voice, then optionally the oldest
// held voice (steal). Retrigger and steal drop the gate for one cycle.
// Optional feature: define VOICE_ALLOC_STEAL_EN to enable voice stealing;
// otherwise a note-on with every voice held is discarded and `dropped` pulses.
module voice_allocator #(
    parameter int unsigned VOICES    = 4,
    parameter int unsigned NOTE_BITS = 7
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ev_valid,
    output logic                          ev_ready,
    input  logic                          ev_on,
    input  logic [NOTE_BITS-1:0]          ev_note,
    input  logic [VOICES-1:0]             active,
    output logic [VOICES-1:0]             gate,
    output logic [VOICES*NOTE_BITS-1:0]   note,
    output logic                          dropped
);

    localparam int unsigned IW = $clog2(VOICES);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_REGATE = 1'b1;

    logic [VOICES-1:0]    gate_q, gate_d;
    logic [NOTE_BITS-1:0] note_q [VOICES];
    logic [NOTE_BITS-1:0] note_d [VOICES];
    logic [IW-1:0]        rank_q [VOICES];
    logic [IW-1:0]        rank_d [VOICES];
    logic [0:0]           state_q, state_d;
    logic [IW-1:0]        tgt_q, tgt_d;
    logic                 dropped_q, dropped_d;

    logic [VOICES-1:0] rel, free, match;
    logic              match_any, free_any, rel_any;
    logic [IW-1:0]     match_idx, free_idx, rel_idx;
`ifdef VOICE_ALLOC_STEAL_EN
    logic              held_any;
    logic [IW-1:0]     held_idx;
`endif

    // Classify voices and find the candidate for each selection rule
    always_comb begin
        rel       = ~gate_q & active;
        free      = ~gate_q & ~active;
        match_any = 1'b0;
        match_idx = '0;
        free_any  = 1'b0;
        free_idx  = '0;
        rel_any   = 1'b0;
        rel_idx   = '0;
`ifdef VOICE_ALLOC_STEAL_EN
        held_any  = 1'b0;
        held_idx  = '0;
`endif
        for (int i = 0; i < VOICES; i++) begin
            match[i] = gate_q[i] && (note_q[i] == ev_note);
            if (match[i] && !match_any) begin
                match_any = 1'b1;
                match_idx = IW'(i);
            end
            if (free[i] && !free_any) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
            if (rel[i] && (!rel_any || rank_q[i] > rank_q[rel_idx])) begin
                rel_any = 1'b1;
                rel_idx = IW'(i);
            end
`ifdef VOICE_ALLOC_STEAL_EN
            if (gate_q[i] && (!held_any || rank_q[i] > rank_q[held_idx])) begin
                held_any = 1'b1;
                held_idx = IW'(i);
            end
`endif
        end
    end

    logic          alloc, regate;
    logic [IW-1:0] alloc_idx;

    // Event handling, LRU update and regate sequencing
    always_comb begin
        gate_d    = gate_q;
        note_d    = note_q;
        rank_d    = rank_q;
        state_d   = ST_IDLE;
        tgt_d     = tgt_q;
        dropped_d = 1'b0;
        alloc     = 1'b0;
        alloc_idx = '0;
        regate    = 1'b0;
        if (state_q == ST_REGATE) begin
            gate_d[tgt_q] = 1'b1;
        end else if (ev_valid) begin
            if (ev_on) begin
                if (match_any) begin
                    alloc     = 1'b1;
                    alloc_idx = match_idx;
                    regate    = 1'b1;
                end else if (free_any) begin
                    alloc     = 1'b1;
                    alloc_idx = free_idx;
                end else if (rel_any) begin
                    alloc     = 1'b1;
                    alloc_idx = rel_idx;
                end else begin
`ifdef VOICE_ALLOC_STEAL_EN
                    alloc     = held_any;
                    alloc_idx = held_idx;
                    regate    = held_any;
`else
                    dropped_d = 1'b1;
`endif
                end
            end else if (match_any) begin
                gate_d[match_idx] = 1'b0;
            end
        end
        if (alloc) begin
            note_d[alloc_idx] = ev_note;
            // Regated voices sit low for one cycle before rising
            gate_d[alloc_idx] = !regate;
            for (int i = 0; i < VOICES; i++) begin
                if (rank_q[i] < rank_q[alloc_idx]) begin
                    rank_d[i] = rank_q[i] + 1'b1;
                end
            end
            rank_d[alloc_idx] = '0;
            if (regate) begin
                state_d = ST_REGATE;
                tgt_d   = alloc_idx;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gate_q    <= '0;
            state_q   <= ST_IDLE;
            tgt_q     <= '0;
            dropped_q <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                note_q[i] <= '0;
                rank_q[i] <= IW'(i);
            end
        end else begin
            gate_q    <= gate_d;
            note_q    <= note_d;
            rank_q    <= rank_d;
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            dropped_q <= dropped_d;
        end
    end

    // Output mapping
    always_comb begin
        for (int i = 0; i < VOICES; i++) begin
            note[i*NOTE_BITS +: NOTE_BITS] = note_q[i];
        end
    end

    assign gate     = gate_q;
    assign ev_ready = (state_q == ST_IDLE);
    assign dropped  = dropped_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator (VOICES=4, NOTE_BITS=7).
// Expected output snapshots are queued when stimulus is driven and compared
// against the DUT one edge later. Build with VOICE_ALLOC_STEAL_EN to check
// the stealing variant.
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        ev_valid = 1'b0;
    logic        ev_on = 1'b0;
    logic [6:0]  ev_note = '0;
    logic [3:0]  act = '0;
    logic        ev_ready, dropped;
    logic [3:0]  gate;
    logic [27:0] note;

    typedef struct packed {
        logic [3:0]  g;
        logic [27:0] n;
        logic        r;
        logic        d;
    } snap_t;

    snap_t sb[$];
    snap_t e;
    int    n_vec = 0;
    int    n_err = 0;

    voice_allocator #(.VOICES(4), .NOTE_BITS(7)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_on    (ev_on),
        .ev_note  (ev_note),
        .active   (act),
        .gate     (gate),
        .note     (note),
        .dropped  (dropped)
    );

    always #5 clk = ~clk;

    function automatic snap_t obs();
        return {gate, note, ev_ready, dropped};
    endfunction

    function automatic snap_t mk(input logic [3:0] g, input logic [27:0] n,
                                 input logic r, input logic d);
        snap_t s;
        s.g = g; s.n = n; s.r = r; s.d = d;
        return s;
    endfunction

    function automatic logic [27:0] nb(input int a, input int b, input int c, input int d);
        return {7'(d), 7'(c), 7'(b), 7'(a)};
    endfunction

    // One clock of stimulus; starts and ends on a falling edge
    task automatic cyc(input logic v, input logic on, input int nt);
        ev_valid = v;
        ev_on    = on;
        ev_note  = 7'(nt);
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
    endtask

    task automatic drive(input logic v, input logic on, input int nt, input snap_t exp);
        sb.push_back(exp);
        cyc(v, on, nt);
    endtask

    task automatic do_reset();
        ev_valid = 1'b0;
        act      = '0;
        reset_n  = 1'b0;
        @(negedge clk);
        reset_n  = 1'b1;
    endtask

    task automatic fill();
        cyc(1, 1, 60); cyc(1, 1, 62); cyc(1, 1, 64); cyc(1, 1, 65);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        sb.push_back(mk(4'b0000, 28'h0, 1'b1, 1'b0));
        @(negedge clk);
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL reset: got %h want %h", obs(), e); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_on();
        do_reset();
        drive(1, 1, 60, mk(4'b0001, nb(60, 0, 0, 0), 1'b1, 1'b0));
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL first_on: got %h want %h", obs(), e); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1, 1, 60, mk(4'b0001, nb(60, 0, 0, 0), 1'b1, 1'b0));
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL b2b_on0: got %h want %h", obs(), e); end
        drive(1, 1, 62, mk(4'b0011, nb(60, 62, 0, 0), 1'b1, 1'b0));
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL b2b_on1: got %h want %h", obs(), e); end
        drive(1, 1, 64, mk(4'b0111, nb(60, 62, 64, 0), 1'b1, 1'b0));
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL b2b_on2: got %h want %h", obs(), e); end
        drive(1, 1, 65, mk(4'b1111, nb(60, 62, 64, 65), 1'b1, 1'b0));
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL b2b_on3: got %h want %h", obs(), e); end
        act = 4'b1111;
        drive(1, 0, 62, mk(4'b1101, nb(60, 62, 64, 65), 1'b1, 1'b0));
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL b2b_off62: got %h want %h", obs(), e); end
        // Voice 1 is releasing (active high), the only non-held voice
        drive(1, 1, 67, mk(4'b1111, nb(60, 67, 64, 65), 1'b1, 1'b0));
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL b2b_reuse: got %h want %h", obs(), e); end
    endtask

    task automatic test_full();
        do_reset();
        fill();
        act = 4'b1111;
        sb.push_back(mk(4'b1111, nb(60, 62, 64, 65), 1'b1, 1'b0));
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL full_fill: got %h want %h", obs(), e); end
`ifdef VOICE_ALLOC_STEAL_EN
        drive(1, 1, 69, mk(4'b1110, nb(69, 62, 64, 65), 1'b0, 1'b0));
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL steal_low: got %h want %h", obs(), e); end
        // Event offered while not ready must not be taken
        drive(1, 1, 70, mk(4'b1111, nb(69, 62, 64, 65), 1'b1, 1'b0));
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL steal_high: got %h want %h", obs(), e); end
        drive(0, 0, 0, mk(4'b1111, nb(69, 62, 64, 65), 1'b1, 1'b0));
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL steal_idle: got %h want %h", obs(), e); end
`else
        drive(1, 1, 69, mk(4'b1111, nb(60, 62, 64, 65), 1'b1, 1'b1));
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL drop_pulse: got %h want %h", obs(), e); end
        drive(0, 0, 0, mk(4'b1111, nb(60, 62, 64, 65), 1'b1, 1'b0));
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL drop_end: got %h want %h", obs(), e); end
`endif
    endtask

    task automatic test_retrigger();
        do_reset();
        cyc(1, 1, 60);
        cyc(1, 1, 62);
        drive(1, 1, 60, mk(4'b0010, nb(60, 62, 0, 0), 1'b0, 1'b0));
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL retrig_low: got %h want %h", obs(), e); end
        drive(0, 0, 0, mk(4'b0011, nb(60, 62, 0, 0), 1'b1, 1'b0));
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL retrig_high: got %h want %h", obs(), e); end
        cyc(1, 1, 64);
        cyc(1, 1, 65);
        act = 4'b1111;
        drive(1, 0, 60, mk(4'b1110, nb(60, 62, 64, 65), 1'b1, 1'b0));
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL retrig_off60: got %h want %h", obs(), e); end
        drive(1, 0, 62, mk(4'b1100, nb(60, 62, 64, 65), 1'b1, 1'b0));
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL retrig_off62: got %h want %h", obs(), e); end
        // Retrigger made voice 0 newer than voice 1, so voice 1 is the oldest releasing
        drive(1, 1, 70, mk(4'b1110, nb(60, 70, 64, 65), 1'b1, 1'b0));
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL retrig_lru: got %h want %h", obs(), e); end
    endtask

    task automatic test_noteoff_nomatch();
        do_reset();
        cyc(1, 1, 60);
        drive(1, 0, 50, mk(4'b0001, nb(60, 0, 0, 0), 1'b1, 1'b0));
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL off_nomatch: got %h want %h", obs(), e); end
    endtask

    task automatic test_reset_mid_regate();
        do_reset();
        cyc(1, 1, 60);
        cyc(1, 1, 60);
        reset_n = 1'b0;
        sb.push_back(mk(4'b0000, 28'h0, 1'b1, 1'b0));
        #1;
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL midreg_reset: got %h want %h", obs(), e); end
        @(negedge clk);
        reset_n = 1'b1;
        drive(1, 1, 61, mk(4'b0001, nb(61, 0, 0, 0), 1'b1, 1'b0));
        e = sb.pop_front(); n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL midreg_after: got %h want %h", obs(), e); end
    endtask

    initial begin
        test_reset();
        test_first_on();
        test_back_to_back();
        test_full();
        test_retrigger();
        test_noteoff_nomatch();
        test_reset_mid_regate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
